// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher with PC-tagged response queue and redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating flush/empty event counters.
module fetch_prefetch_queue #(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_inst,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_inst
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] flush_count,
   output logic [31:0] empty_count
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1) + 1;
   localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [TW-1:0] TLAST = TW'(MAX_OUTSTANDING - 1);
   localparam logic [31:0]   NOP   = 32'h0000_0013;

   logic [31:0]   r_q_pc   [DEPTH];
   logic [31:0]   r_q_inst [DEPTH];
   logic [31:0]   r_tag    [MAX_OUTSTANDING];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [TW-1:0] r_tw;
   logic [TW-1:0] r_tr;
   logic [CW-1:0] r_occ;
   logic [CW-1:0] r_out;
   logic [CW-1:0] r_drop;
   logic [31:0]   r_req_pc;

   logic          w_room;
   logic          w_fire;
   logic          w_rsp;
   logic          w_keep;
   logic          w_pop;
   logic [TW-1:0] w_tw_nxt;
   logic [TW-1:0] w_tr_nxt;

   // Occupancy plus in-flight never exceeds DEPTH, so queue cannot overflow.
   assign w_room = (r_out < CW'(MAX_OUTSTANDING))
                 && ((r_occ + r_out) < CW'(DEPTH));

   assign imem_req_valid = !reset && !br_taken && w_room;
   assign imem_req_addr  = r_req_pc;
   assign w_fire         = imem_req_valid && imem_req_ready;

   // Responses with nothing outstanding are protocol errors and ignored.
   assign w_rsp  = imem_rsp_valid && (r_out != '0);
   assign w_keep = w_rsp && (r_drop == '0) && !br_taken;

   assign fetch_valid = !reset && !br_taken && (r_occ != '0);
   assign fetch_pc    = fetch_valid ? r_q_pc[r_rd]   : 32'h0;
   assign fetch_inst  = fetch_valid ? r_q_inst[r_rd] : NOP;
   assign w_pop       = fetch_valid && !stall;

   assign w_tw_nxt = (r_tw == TLAST) ? '0 : r_tw + TW'(1);
   assign w_tr_nxt = (r_tr == TLAST) ? '0 : r_tr + TW'(1);

   always_ff @(posedge clock) begin
      if (w_fire) begin
         r_tag[r_tw] <= r_req_pc;
      end
      if (w_keep) begin
         r_q_pc[r_wr]   <= r_tag[r_tr];
         r_q_inst[r_wr] <= imem_rsp_inst;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr     <= '0;
         r_rd     <= '0;
         r_tw     <= '0;
         r_tr     <= '0;
         r_occ    <= '0;
         r_out    <= '0;
         r_drop   <= '0;
         r_req_pc <= RESET_PC;
      end else begin
         if (w_fire) begin
            r_tw <= w_tw_nxt;
         end
         if (w_rsp) begin
            r_tr <= w_tr_nxt;
         end
         r_out <= r_out + CW'(w_fire) - CW'(w_rsp);
         if (br_taken) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_occ    <= '0;
            r_req_pc <= {br_target[31:2], 2'b00};
            r_drop   <= r_out - CW'(w_rsp);
         end else begin
            if (w_fire) begin
               r_req_pc <= r_req_pc + 32'd4;
            end
            if (w_rsp && (r_drop != '0)) begin
               r_drop <= r_drop - CW'(1);
            end
            if (w_keep) begin
               r_wr <= r_wr + PW'(1);
            end
            if (w_pop) begin
               r_rd <= r_rd + PW'(1);
            end
            r_occ <= r_occ + CW'(w_keep) - CW'(w_pop);
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_flush;
   logic [31:0] r_empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_flush <= '0;
         r_empty <= '0;
      end else begin
         if (br_taken && (r_flush != '1)) begin
            r_flush <= r_flush + 32'd1;
         end
         if (!fetch_valid && (r_empty != '1)) begin
            r_empty <= r_empty + 32'd1;
         end
      end
   end

   assign flush_count = r_flush;
   assign empty_count = r_empty;
`endif

endmodule
